// File: rtl/vol_sqrt_mul_if.sv
// Start/busy/valid handshake bundle for the sigma * sqrt(T) multiplier.
// Master drives the request and operands; slave returns status and result.
interface vol_sqrt_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] sigma;
  logic [WIDTH-1:0] sqrt_t;
  logic [WIDTH-1:0] prod;
  logic             ovf;

  modport master (
    output start, sigma, sqrt_t,
    input  busy, valid, prod, ovf
  );

  modport slave (
    input  start, sigma, sqrt_t,
    output busy, valid, prod, ovf
  );
endinterface

// File: rtl/vol_sqrt_mul.sv
// Sequential unsigned Q16.16 shift-add multiplier forming sigma * sqrt(T), one multiplier bit per cycle.
// Define VOL_MUL_SATURATE_EN to clamp prod to all-ones on integer overflow instead of wrapping.
module vol_sqrt_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 16
) (
  input  logic           clk,
  input  logic           reset,
  vol_sqrt_mul_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    p_sum;

  // State and datapath registers; reset drops any in-flight multiply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath; the final iteration's sum feeds the result directly.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    p_sum   = p_q + (b_q[0] ? a_q : '0);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = PW'(bus.sigma);
          b_d     = bus.sqrt_t;
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        p_d   = p_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          ovf_d   = |p_sum[PW-1:WIDTH+FBITS];
`ifdef VOL_MUL_SATURATE_EN
          prod_d  = ovf_d ? '1 : p_sum[WIDTH+FBITS-1:FBITS];
`else
          prod_d  = p_sum[WIDTH+FBITS-1:FBITS];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.prod  = prod_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_vol_sqrt_mul.sv
// Self-checking bench for vol_sqrt_mul against a full-width arithmetic product model.
// Covers reset, directed and random products, handshake corner cases and mid-operation reset.
module tb_vol_sqrt_mul;

  localparam int unsigned WIDTH = 32;
  localparam int LAT = 32;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  vol_sqrt_mul_if #(.WIDTH(WIDTH)) bus ();

  vol_sqrt_mul #(.WIDTH(WIDTH), .FBITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact 64-bit product, take the Q16.16 window, flag integer overflow.
  function automatic void model(input logic [31:0] s, input logic [31:0] r,
                                output logic [31:0] p, output logic o);
    logic [63:0] f;
    f = {32'd0, s} * {32'd0, r};
    p = f[47:16];
    o = (f[63:48] != 16'd0);
`ifdef VOL_MUL_SATURATE_EN
    if (o) p = 32'hFFFF_FFFF;
`endif
  endfunction

  // Issue one request (caller sits at a negedge) and wait, bounded, for valid.
  task automatic do_mul(input logic [31:0] s, input logic [31:0] r,
                        output logic [31:0] p, output logic o,
                        output int lat, output int bcnt);
    bus.sigma  = s;
    bus.sqrt_t = r;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.sigma  = $urandom;
    bus.sqrt_t = $urandom;
    lat  = -1;
    bcnt = 0;
    for (int n = 0; n <= LAT + 8; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.valid === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.busy === 1'b1) bcnt++;
    end
    p = bus.prod;
    o = bus.ovf;
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.sigma  = '0;
    bus.sqrt_t = '0;
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    tests_run++; if (bus.prod !== 32'd0) begin tests_failed++; $display("FAIL reset_prod got %h want 0", bus.prod); end
    tests_run++; if (bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] s_tab [4] = '{32'h0000_3333, 32'h0001_8000, 32'h0100_0000, 32'h0000_0000};
    logic [31:0] r_tab [4] = '{32'h0002_0000, 32'h0004_78DD, 32'h0100_0000, 32'hFFFF_FFFF};
    logic [31:0] p_tab [4];
    logic        o_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] p, pm;
    logic        o, om;
    int          lat, bcnt;
    p_tab[0] = 32'h0000_6666;
    p_tab[1] = 32'h0006_B54B;
`ifdef VOL_MUL_SATURATE_EN
    p_tab[2] = 32'hFFFF_FFFF;
`else
    p_tab[2] = 32'h0000_0000;
`endif
    p_tab[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      do_mul(s_tab[i], r_tab[i], p, o, lat, bcnt);
      model(s_tab[i], r_tab[i], pm, om);
      tests_run++; if (p !== p_tab[i]) begin tests_failed++; $display("FAIL directed%0d_prod got %h want %h", i, p, p_tab[i]); end
      tests_run++; if (p !== pm) begin tests_failed++; $display("FAIL directed%0d_model got %h want %h", i, p, pm); end
      tests_run++; if (o !== o_tab[i]) begin tests_failed++; $display("FAIL directed%0d_ovf got %b want %b", i, o, o_tab[i]); end
      tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, LAT); end
      tests_run++; if (bcnt !== LAT) begin tests_failed++; $display("FAIL directed%0d_busy_cycles got %0d want %0d", i, bcnt, LAT); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] s, r, p, pm;
    logic        o, om;
    int          lat, bcnt;
    for (int i = 0; i < 16; i++) begin
      s = $urandom;
      r = $urandom;
      if (i % 2 == 0) begin
        s = s & 32'h00FF_FFFF;
        r = r & 32'h000F_FFFF;
      end
      do_mul(s, r, p, o, lat, bcnt);
      model(s, r, pm, om);
      tests_run++; if (p !== pm) begin tests_failed++; $display("FAIL random%0d_prod s=%h r=%h got %h want %h", i, s, r, p, pm); end
      tests_run++; if (o !== om) begin tests_failed++; $display("FAIL random%0d_ovf got %b want %b", i, o, om); end
      tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL random%0d_latency got %0d want %0d", i, lat, LAT); end
      if ((i % 3) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [31:0] s1, r1, s2, r2, pm;
    logic        om;
    int          n, extra;
    s1 = $urandom & 32'h0003_FFFF;
    r1 = $urandom & 32'h0003_FFFF;
    s2 = s1 ^ 32'h0001_2345;
    r2 = r1 ^ 32'h0002_0F0F;
    model(s1, r1, pm, om);
    bus.sigma = s1; bus.sqrt_t = r1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    bus.sigma = s2; bus.sqrt_t = r2; bus.start = 1'b1;
    @(negedge clk); n++;
    bus.start = 1'b0;
    while (bus.valid !== 1'b1 && n < LAT + 8) begin @(negedge clk); n++; end
    tests_run++; if (n !== LAT) begin tests_failed++; $display("FAIL ignore_latency got %0d want %0d", n, LAT); end
    tests_run++; if (bus.prod !== pm) begin tests_failed++; $display("FAIL ignore_prod got %h want %h", bus.prod, pm); end
    extra = 0;
    repeat (LAT + 4) begin @(negedge clk); if (bus.valid === 1'b1 || bus.busy === 1'b1) extra++; end
    tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL ignore_no_second_op got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s, r, p, pm;
    logic        o, om;
    int          lat, bcnt, vcnt;
    s = $urandom & 32'h00FF_FFFF;
    r = $urandom & 32'h0000_FFFF;
    do_mul(s, r, p, o, lat, bcnt);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_in_valid got %b want 0", bus.busy); end
    s = $urandom & 32'h000F_FFFF;
    r = $urandom & 32'h000F_FFFF;
    do_mul(s, r, p, o, lat, bcnt);
    model(s, r, pm, om);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    tests_run++; if (p !== pm) begin tests_failed++; $display("FAIL b2b_prod got %h want %h", p, pm); end
    tests_run++; if (o !== om) begin tests_failed++; $display("FAIL b2b_ovf got %b want %b", o, om); end
    // Result must hold while idle.
    vcnt = 0;
    repeat (15) begin @(negedge clk); if (bus.valid === 1'b1) vcnt++; end
    tests_run++; if (bus.prod !== pm) begin tests_failed++; $display("FAIL hold_prod got %h want %h", bus.prod, pm); end
    tests_run++; if (vcnt !== 0) begin tests_failed++; $display("FAIL hold_no_valid got %0d pulses want 0", vcnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s, r, p, pm;
    logic        o, om;
    int          lat, bcnt, vcnt;
    bus.sigma = 32'h0001_0000; bus.sqrt_t = 32'h0003_0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_valid got %b want 0", bus.valid); end
    tests_run++; if (bus.prod !== 32'd0) begin tests_failed++; $display("FAIL midreset_prod got %h want 0", bus.prod); end
    tests_run++; if (bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL midreset_ovf got %b want 0", bus.ovf); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    vcnt = 0;
    repeat (LAT + 6) begin @(negedge clk); if (bus.valid === 1'b1) vcnt++; end
    tests_run++; if (vcnt !== 0) begin tests_failed++; $display("FAIL midreset_no_valid got %0d pulses want 0", vcnt); end
    s = 32'h0002_8000;
    r = 32'h0001_4000;
    do_mul(s, r, p, o, lat, bcnt);
    model(s, r, pm, om);
    tests_run++; if (p !== pm) begin tests_failed++; $display("FAIL post_reset_prod got %h want %h", p, pm); end
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
